blink_multi: RTL

- Multi-channel parametrised LED blinker; successor to the single-channel fixed-rate blinker.
- One shared free-running prescaler generates a tick. Each of NCH channels has its own mode, divider and burst count, set through a single-cycle config write port.
- Sits between the board control logic and the LED pins.
- Serves as a liveness-verification target (fairness on rst).

---
 rtl/blink_multi.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/blink_multi.sv
// ---------------------------------------------------------------------------
// blink_multi -- multi-channel LED blinker with one shared prescaler.
//
// A free-running CBITS-wide prescaler produces a tick once every 2^CBITS
// cycles. Each of NCH channels has its own mode, half-period divider and
// burst length. A channel is loaded through a single-cycle config write port.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   cfg_we    in   config write strobe (one cycle)
//   cfg_ch    in   target channel; values >= NCH are ignored
//   cfg_mode  in   0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_div   in   half-period in ticks, minus 1
//   cfg_cnt   in   burst on-pulses, minus 1
//   led       out  registered LED drive, one bit per channel
//   busy      out  channel is inside an active BURST
//   flg       out  registered prescaler-wrap pulse
//
// Optional: define BLINK_MULTI_SVA_EN to add concurrent liveness/safety
// properties. No logic changes when it is defined.
// ---------------------------------------------------------------------------
module blink_multi #(
   parameter int NCH   = 4,
   parameter int CBITS = 20,
   parameter int DIVW  = 4,
   parameter int PW    = 3,
   parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [CHW-1:0]  cfg_ch,
   input  logic [1:0]      cfg_mode,
   input  logic [DIVW-1:0] cfg_div,
   input  logic [PW-1:0]   cfg_cnt,
   output logic [NCH-1:0]  led,
   output logic [NCH-1:0]  busy,
   output logic            flg
);

   typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3} mode_t;

   logic [CBITS-1:0] r_pre;
   logic             r_flg;
   logic             w_tick;

   // Tick is taken from the current prescaler value, so the first tick
   // lands in the first cycle after reset release.
   assign w_tick = (r_pre == '0);
   assign flg    = r_flg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre <= '0;
         r_flg <= 1'b0;
      end else begin
         r_pre <= r_pre + 1'b1;
         r_flg <= w_tick;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      mode_t           r_mode;
      logic [DIVW-1:0] r_div;
      logic [DIVW-1:0] r_dcnt;
      logic            r_phase;
      logic [PW:0]     r_rem;
      logic            r_led;
      logic            r_busy;
      logic            w_wr;
      logic            w_run;
      logic [PW:0]     w_rem_dec;

      // Out-of-range channel numbers never match any instance.
      assign w_wr      = cfg_we && (cfg_ch == CHW'(i));
      assign w_run     = (r_mode == M_BLINK) || (r_mode == M_BURST && r_busy);
      assign w_rem_dec = r_rem - 1'b1;

      assign led[i]  = r_led;
      assign busy[i] = r_busy;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_mode  <= M_OFF;
            r_div   <= '0;
            r_dcnt  <= '0;
            r_phase <= 1'b0;
            r_rem   <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            // LED reflects the state before this edge, hence one cycle behind.
            r_led <= (r_mode == M_ON) ||
                     (r_mode == M_BLINK && r_phase) ||
                     (r_mode == M_BURST && r_busy && r_phase);
            if (w_wr) begin
               // A write overrides a coincident tick on this channel only.
               r_mode  <= mode_t'(cfg_mode);
               r_div   <= cfg_div;
               r_dcnt  <= '0;
               r_phase <= 1'b0;
               r_rem   <= (PW+1)'(cfg_cnt) + 1'b1;
               r_busy  <= (cfg_mode == 2'd3);
            end else if (w_tick && w_run) begin
               if (r_dcnt == r_div) begin
                  r_dcnt  <= '0;
                  r_phase <= ~r_phase;
                  // Falling phase in BURST ends one on-pulse; the last one
                  // drops busy, which freezes the divider with phase at 0.
                  if (r_mode == M_BURST && r_phase) begin
                     r_rem <= w_rem_dec;
                     if (w_rem_dec == '0)
                        r_busy <= 1'b0;
                  end
               end else begin
                  r_dcnt <= r_dcnt + 1'b1;
               end
            end
         end
      end

`ifdef BLINK_MULTI_SVA_EN
      // Steady BLINK without a rewrite must keep lighting the LED.
      a_blink_live: assert property (@(posedge clk) disable iff (rst)
         (r_mode == M_BLINK) |-> s_eventually (r_led || w_wr));
      // A burst always finishes unless the channel is rewritten.
      a_busy_live: assert property (@(posedge clk) disable iff (rst)
         r_busy |-> s_eventually (!r_busy || w_wr));
      // LED is registered, so it follows the mode of the previous cycle.
      a_led_safe: assert property (@(posedge clk) disable iff (rst)
         r_led |-> ($past(r_mode) != M_OFF));
`endif
   end

`ifdef BLINK_MULTI_SVA_EN
   a_flg_live: assert property (@(posedge clk) disable iff (rst)
      1'b1 |-> s_eventually r_flg);
`endif

endmodule
